// File: rtl/apb_master_arbiter14.sv
// apb_master_arbiter14: round-robin arbiter driving one APB master port; optional ACCESS watchdog under APB_ARB_TIMEOUT_EN
module apb_master_arbiter14 #(
  parameter int NUM_REQ        = 4,
  parameter int PADDR_WIDTH14  = 32,
  parameter int PWDATA_WIDTH14 = 32,
  parameter int PRDATA_WIDTH14 = 32,
  parameter int SEL_LSB        = 12,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                              pclock14,
  input  logic                              preset14,
  input  logic [NUM_REQ-1:0]                req_valid,
  input  logic [NUM_REQ*PADDR_WIDTH14-1:0]  req_addr,
  input  logic [NUM_REQ-1:0]                req_write,
  input  logic [NUM_REQ*PWDATA_WIDTH14-1:0] req_wdata,
  output logic [NUM_REQ-1:0]                req_done,
  output logic [PRDATA_WIDTH14-1:0]         req_rdata,
  output logic                              req_slverr,
  output logic                              busy,
  output logic [2:0]                        grant_id,
  output logic                              timeout_pulse,
  output logic [PADDR_WIDTH14-1:0]          paddr14,
  output logic                              prwd14,
  output logic [PWDATA_WIDTH14-1:0]         pwdata14,
  output logic                              penable14,
  output logic [15:0]                       psel14,
  input  logic [PRDATA_WIDTH14-1:0]         prdata14,
  input  logic                              pready14,
  input  logic                              pslverr14
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("NUM_REQ must be 2..8");
  end
  if (SEL_LSB + 4 > PADDR_WIDTH14) begin : g_bad_sel_lsb
    $error("SEL_LSB+4 must not exceed PADDR_WIDTH14");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be 1..65535");
  end
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  state_t state_q;
  logic [IW-1:0] last_q;
  logic [IW-1:0] win_d;
  logic [IW-1:0] idx;
  logic found_d;
  logic [NUM_REQ-1:0] elig;
  logic [PADDR_WIDTH14-1:0] win_addr;
`ifdef APB_ARB_TIMEOUT_EN
  logic [15:0] cnt_q;
`endif
  assign elig = req_valid & ~req_done;
  assign win_addr = req_addr[win_d*PADDR_WIDTH14 +: PADDR_WIDTH14];
  // pick the first eligible requester after the last grant; descending scan lets the nearest one win
  always_comb begin
    win_d = '0;
    found_d = 1'b0;
    idx = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = IW'((int'(last_q) + k) % NUM_REQ);
      if (elig[idx]) begin
        win_d = idx;
        found_d = 1'b1;
      end
    end
  end
  // APB SETUP/ACCESS sequencing with registered bus and completion outputs
  always_ff @(posedge pclock14 or posedge preset14) begin
    if (preset14) begin
      state_q       <= IDLE;
      last_q        <= IW'(NUM_REQ - 1);
      grant_id      <= '0;
      paddr14       <= '0;
      pwdata14      <= '0;
      prwd14        <= 1'b0;
      penable14     <= 1'b0;
      psel14        <= '0;
      req_done      <= '0;
      req_rdata     <= '0;
      req_slverr    <= 1'b0;
      busy          <= 1'b0;
      timeout_pulse <= 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
      cnt_q         <= '0;
`endif
    end else begin
      req_done      <= '0;
      timeout_pulse <= 1'b0;
      case (state_q)
        IDLE: if (found_d) begin
          paddr14  <= win_addr;
          prwd14   <= req_write[win_d];
          pwdata14 <= req_wdata[win_d*PWDATA_WIDTH14 +: PWDATA_WIDTH14];
          psel14   <= 16'(1) << win_addr[SEL_LSB +: 4];
          grant_id <= 3'(win_d);
          last_q   <= win_d;
          busy     <= 1'b1;
          state_q  <= SETUP;
`ifdef APB_ARB_TIMEOUT_EN
          cnt_q    <= '0;
`endif
        end
        SETUP: begin
          penable14 <= 1'b1;
          state_q   <= ACCESS;
        end
        ACCESS: if (pready14) begin
          req_done   <= NUM_REQ'(1) << grant_id;
          req_rdata  <= prwd14 ? '0 : prdata14;
          req_slverr <= pslverr14;
          psel14     <= '0;
          penable14  <= 1'b0;
          busy       <= 1'b0;
          state_q    <= IDLE;
        end
`ifdef APB_ARB_TIMEOUT_EN
        else if (cnt_q == 16'(TIMEOUT_CYCLES - 1)) begin
          req_done      <= NUM_REQ'(1) << grant_id;
          req_rdata     <= '0;
          req_slverr    <= 1'b1;
          timeout_pulse <= 1'b1;
          psel14        <= '0;
          penable14     <= 1'b0;
          busy          <= 1'b0;
          state_q       <= IDLE;
        end else begin
          cnt_q <= cnt_q + 16'd1;
        end
`endif
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
